// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES-128 inverse cipher datapath.
// Byte k of a 128-bit block sits at bits [8k +: 8] of a [0:127] vector,
// at row k%4, column k/4.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    typedef logic [0:127] block_t;

    // Bit offset of the byte at (row, col) inside a block_t.
    function automatic int byte_off(input int row, input int col);
        return 8 * (4 * col + row);
    endfunction

    // Multiply by x in GF(2^8) with the AES modulus 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
    function automatic block_t inv_shift_rows(input block_t s);
        block_t o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[byte_off(r, c) +: 8] = s[byte_off(r, (c - r + 4) % 4) +: 8];
            end
        end
        return o;
    endfunction

    // One column times the circulant {0e,0b,0d,09}; row 0 is the top byte.
    // Every product comes from the x2/x4/x8 xtime chain of each input byte.
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8 * i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        for (int i = 0; i < 4; i++) begin
            o[31 - 8 * i -: 8] = me[i] ^ mb[(i + 1) % 4] ^ md[(i + 2) % 4] ^ m9[(i + 3) % 4];
        end
        return o;
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box: one 8-bit combinational table lookup.
module inv_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);

    // Entry n lives at bits [8n +: 8]; rows are 16 consecutive entries.
    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign y = INV_SBOX[{x, 3'b000} +: 8];

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Round keys come from an external store addressed by the registered key_idx
// and are returned combinationally in the same cycle.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A source holds valid and its data stable until that edge;
// ready may change freely and never depends combinationally on valid.
// Here in_ready is high only in IDLE, out_valid only in DONE.
module aes_decrypt_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] cipher_in,
    output logic [3:0]   key_idx,
    input  logic [0:127] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] plain_out,
    output fsm_t         dbg_state
);

    fsm_t   fsm_q;
    fsm_t   fsm_d;
    block_t state_q;
    logic [3:0] rnd;

    block_t isr;
    block_t sb;
    block_t ark;
    block_t imc;

    assign isr = inv_shift_rows(state_q);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .x(isr[8 * i +: 8]),
            .y(sb[8 * i +: 8])
        );
    end

    assign ark = sb ^ round_key;

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign imc[32 * c +: 32] = inv_mix_column(ark[32 * c +: 32]);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        fsm_d     = fsm_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_d = ROUND;
            end
            ROUND: begin
                if (rnd == 4'd1) fsm_d = FINAL;
            end
            FINAL: begin
                fsm_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Block state, round counter and key request; key_idx always names the
    // key that the current state consumes this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            rnd     <= '0;
            key_idx <= 4'(NR);
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= cipher_in ^ round_key;
                        rnd     <= 4'(NR - 1);
                        key_idx <= 4'(NR - 1);
                    end
                end
                ROUND: begin
                    state_q <= imc;
                    if (rnd == 4'd1) begin
                        key_idx <= 4'd0;
                    end else begin
                        rnd     <= rnd - 4'd1;
                        key_idx <= rnd - 4'd1;
                    end
                end
                FINAL: begin
                    state_q <= ark;
                end
                DONE: begin
                    if (out_ready) key_idx <= 4'(NR);
                end
                default: ;
            endcase
        end
    end

    // Plaintext is only presented while it is valid; it holds while stalled.
    assign plain_out = out_valid ? state_q : '0;
    assign dbg_state = fsm_q;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Self-checking bench for aes_decrypt_core: FIPS-197 vector, back-pressure,
// busy ignore, mid-flight reset, back-to-back blocks and random round trips.
module tb_aes_decrypt_core;
    import aes_pkg::*;

    localparam logic [0:127] FIPS_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] FIPS_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] FIPS_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] FIPS_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [0:127] OTHER_CT  = 128'hdeadbeef0123456789abcdeffedcba98;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [0:127] cipher_in = '0;
    logic [3:0]   key_idx;
    logic [0:127] round_key;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [0:127] plain_out;
    fsm_t         dbg_state;

    always #5 clk = ~clk;

    aes_decrypt_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cipher_in(cipher_in),
        .key_idx  (key_idx),
        .round_key(round_key),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .plain_out(plain_out),
        .dbg_state(dbg_state)
    );

    // ---------------- key store and reference model ----------------
    logic [0:127] rk [0:10];
    logic [7:0]   sbox_tab [0:255];

    assign round_key = (key_idx <= 4'd10) ? rk[key_idx] : '0;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // Forward S-box from its definition: GF inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic load_keys(input logic [0:127] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int i = 0; i < 4; i++) w[i] = key[32 * i +: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
                  ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [0:127] sub_bytes(input logic [0:127] s);
        logic [0:127] o;
        for (int k = 0; k < 16; k++) o[8 * k +: 8] = sbox_tab[s[8 * k +: 8]];
        return o;
    endfunction

    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8 * (4 * c + r) +: 8] = s[8 * (4 * ((c + r) % 4) + r) +: 8];
        return o;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0] a [4];
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[8 * (4 * c + i) +: 8];
            for (int i = 0; i < 4; i++)
                o[8 * (4 * c + i) +: 8] = gmul(a[i], 8'h02) ^ gmul(a[(i + 1) % 4], 8'h03)
                                        ^ a[(i + 2) % 4] ^ a[(i + 3) % 4];
        end
        return o;
    endfunction

    // Forward cipher with the round keys currently in the key store.
    function automatic logic [0:127] encrypt(input logic [0:127] pt);
        logic [0:127] s;
        s = pt ^ rk[0];
        for (int r = 1; r < 10; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ rk[r];
        return shift_rows(sub_bytes(s)) ^ rk[10];
    endfunction

    // ---------------- driver / scoreboard ----------------
    // Called at a negedge: waits for in_ready, presents one block for one edge.
    task automatic drive_block(input logic [0:127] ct, input logic [127:0] exp);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        in_valid  = 1'b1;
        cipher_in = ct;
        exp_q.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for out_valid and compares plain_out against the oldest expectation.
    task automatic sb_collect(input string name);
        int n;
        logic [127:0] exp;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid timeout after %0d cycles", name, n);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected output got=%h", name, plain_out);
        end else begin
            exp = exp_q.pop_front();
            if (plain_out !== exp) begin
                errors++;
                $display("FAIL %s plain_out got=%h expected=%h", name, plain_out, exp);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b expected=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b expected=0", out_valid); end
        checks++; if (plain_out !== '0) begin errors++; $display("FAIL rst_plain_out got=%h expected=0", plain_out); end
        checks++; if (key_idx !== 4'd10) begin errors++; $display("FAIL rst_key_idx got=%0d expected=10", key_idx); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state got=%0d expected=%0d", dbg_state, IDLE); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%b expected=1", in_ready); end
    endtask

    task automatic test_fips();
        load_keys(FIPS_KEY);
        checks++;
        if (rk[10] !== FIPS_RK10) begin errors++; $display("FAIL model_rk10 got=%h expected=%h", rk[10], FIPS_RK10); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (key_idx !== 4'd10) begin errors++; $display("FAIL fips_key_idle got=%0d expected=10", key_idx); end
        drive_block(FIPS_CT, FIPS_PT);
        for (int i = 9; i >= 0; i--) begin
            checks++;
            if (key_idx !== 4'(i)) begin errors++; $display("FAIL fips_key_seq got=%0d expected=%0d", key_idx, i); end
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL fips_early_valid at key %0d got=%b expected=0", i, out_valid); end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fips_latency out_valid got=%b expected=1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fips_done_in_ready got=%b expected=0", in_ready); end
        sb_collect("fips_pt");
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fips_idle_in_ready got=%b expected=1", in_ready); end
        checks++; if (key_idx !== 4'd10) begin errors++; $display("FAIL fips_idle_key got=%0d expected=10", key_idx); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fips_idle_out_valid got=%b expected=0", out_valid); end
    endtask

    task automatic test_backpressure();
        load_keys(FIPS_KEY);
        out_ready = 1'b0;
        drive_block(FIPS_CT, FIPS_PT);
        sb_collect("bp_pt");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d got=%b expected=1", i, out_valid); end
            checks++; if (plain_out !== FIPS_PT) begin errors++; $display("FAIL bp_hold_data cycle %0d got=%h expected=%h", i, plain_out, FIPS_PT); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got=%b expected=0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b expected=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b expected=1", in_ready); end
        checks++; if (key_idx !== 4'd10) begin errors++; $display("FAIL bp_release_key got=%0d expected=10", key_idx); end
    endtask

    task automatic test_busy_ignore();
        load_keys(FIPS_KEY);
        out_ready = 1'b1;
        drive_block(FIPS_CT, FIPS_PT);
        repeat (3) @(negedge clk);
        in_valid  = 1'b1;
        cipher_in = OTHER_CT;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (key_idx !== 4'd5) begin errors++; $display("FAIL busy_key_idx got=%0d expected=5", key_idx); end
        checks++; if (dbg_state !== ROUND) begin errors++; $display("FAIL busy_state got=%0d expected=%0d", dbg_state, ROUND); end
        sb_collect("busy_pt");
        repeat (4) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL busy_no_second got=%b expected=0", out_valid); end
        checks++; if (key_idx !== 4'd10) begin errors++; $display("FAIL busy_idle_key got=%0d expected=10", key_idx); end
    endtask

    task automatic test_reset_mid();
        load_keys(FIPS_KEY);
        out_ready = 1'b1;
        drive_block(FIPS_CT, FIPS_PT);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b expected=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b expected=1", in_ready); end
        checks++; if (key_idx !== 4'd10) begin errors++; $display("FAIL midrst_key got=%0d expected=10", key_idx); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL midrst_state got=%0d expected=%0d", dbg_state, IDLE); end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_block(FIPS_CT, FIPS_PT);
        sb_collect("midrst_next_pt");
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [0:127] pts [3];
        logic [0:127] cts [3];
        int acc_cyc [3];
        int j;
        int got;
        int cyc;
        logic [127:0] exp;
        load_keys(FIPS_KEY);
        for (int k = 0; k < 3; k++) begin
            pts[k] = {$urandom, $urandom, $urandom, $urandom};
            cts[k] = encrypt(pts[k]);
            acc_cyc[k] = 0;
        end
        j = 0;
        got = 0;
        cyc = 0;
        out_ready = 1'b1;
        while (got < 3 && cyc < 80) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_pt unexpected output got=%h", plain_out);
                end else begin
                    exp = exp_q.pop_front();
                    if (plain_out !== exp) begin
                        errors++;
                        $display("FAIL b2b_pt block %0d got=%h expected=%h", got, plain_out, exp);
                    end
                end
                got++;
            end
            if (j < 3) begin
                in_valid = 1'b1;
                if (in_ready === 1'b1) begin
                    cipher_in = cts[j];
                    exp_q.push_back(pts[j]);
                    acc_cyc[j] = cyc;
                    j++;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (got !== 3) begin errors++; $display("FAIL b2b_count got=%0d expected=3", got); end
        checks++; if (acc_cyc[1] - acc_cyc[0] !== 12) begin errors++; $display("FAIL b2b_gap01 got=%0d expected=12", acc_cyc[1] - acc_cyc[0]); end
        checks++; if (acc_cyc[2] - acc_cyc[1] !== 12) begin errors++; $display("FAIL b2b_gap12 got=%0d expected=12", acc_cyc[2] - acc_cyc[1]); end
    endtask

    task automatic test_round_trip();
        logic [0:127] key;
        logic [0:127] pt;
        logic [0:127] ct;
        out_ready = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 100; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            load_keys(key);
            ct = encrypt(pt);
            drive_block(ct, pt);
            sb_collect("round_trip");
            @(negedge clk);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        build_sbox();
        load_keys(FIPS_KEY);
        test_reset();
        test_fips();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_round_trip();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_decrypt_core.md
# aes_decrypt_core

Iterative AES-128 inverse cipher (FIPS-197 §5.3) that accepts one 128-bit ciphertext block, runs ten decryption rounds at one round per clock, and returns the plaintext block. It is the decryption counterpart to the existing encryption datapath (SubBytes / ShiftRow / MixColumns / AddRoundKey). It uses the same byte ordering and reads pre-expanded round keys from an external key store by index.

## Interface
- `NR`, 10: number of rounds. AES-128 only; other values are unsupported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `cipher_in` is valid.
- `in_ready`  out  1  core can accept a block (high only in IDLE).
- `cipher_in`  in  [0:127]  ciphertext. Byte k = bits [8k +: 8], at row k%4, column k/4.
- `key_idx`  out  4  round-key index requested from the key store. Registered.
- `round_key`  in  [0:127]  key word for `key_idx`, returned combinationally in the same cycle.
- `out_valid`  out  1  `plain_out` is valid.
- `out_ready`  in  1  downstream accepts `plain_out`.
- `plain_out`  out  [0:127]  plaintext, same byte ordering as `cipher_in`.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE.
- Round counter `rnd`: 4 bits.
- **IDLE**
  - `in_ready=1`, `key_idx=10`.
  - On `in_valid & in_ready`: `state <= cipher_in ^ round_key` (AddRoundKey with key 10), `rnd <= 9`, go to ROUND.
- **ROUND**
  - `key_idx = rnd`.
  - `state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key)`.
  - If `rnd == 1`: go to FINAL with `key_idx <= 0`. Otherwise `rnd <= rnd-1`.
- **FINAL**
  - `key_idx = 0`.
  - `state <= InvSubBytes(InvShiftRows(state)) ^ round_key`.
  - Go to DONE.
- **DONE**
  - `out_valid=1`, `plain_out = state`.
  - On `out_ready`: go to IDLE, `key_idx <= 10`.
- InvShiftRows: row r rotates right by r. `out[row r, col c] = in[row r, col (c-r) mod 4]`. Row 0 is unchanged.
- InvMixColumns: each column is multiplied in GF(2^8), modulus 0x11B, by the matrix rows {0e,0b,0d,09} in circulant order. Build it from xtime chains. No general multiplier.
- InvSubBytes: 16 parallel inverse S-box lookups.
- Boundary conditions:
  - `in_valid` outside IDLE: ignored. No queueing.
  - DONE with `out_ready=1`: `in_ready` stays 0 that cycle. No bypass into a new block.
  - `out_ready` held low: `plain_out` and `out_valid` hold indefinitely and are bit-stable.
  - `rst_n` low at any point: the in-flight block is discarded and the FSM returns to IDLE.
  - `round_key` is sampled only in IDLE-accept, ROUND and FINAL cycles.

## Timing
- Reset values:
  - FSM = IDLE, `in_ready=1`.
  - `out_valid=0`, `plain_out=0`, `state=0`.
  - `key_idx=10`, `rnd=0`.
- Latency: accept at edge T. ROUND covers edges T+1..T+9. FINAL is edge T+10. `out_valid` is high after edge T+10.
- Throughput: one block per 12 cycles minimum (accept, 9 rounds, final, handshake, then IDLE for one cycle).
- Key-request sequence per block: 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0.
- Key store contract: combinational read, which gives zero-cycle key latency.

## Structure
- Shared package `aes_pkg`:
  - FSM enum.
  - `NR`.
  - `xtime` function.
  - `inv_shift_rows` function.
  - `inv_mix_column` function (32-bit).
  - Byte-index helper (row, col → bit offset).
- Sub-module `inv_sbox`: 8-bit combinational lookup table, instantiated 16×.

## Test plan
- FIPS-197 C.1 vector: key store holds the expansion of key 000102030405060708090a0b0c0d0e0f (rk10 = 13111d7fe3944a17f307a78b4d2b30c5). Ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a → `plain_out` 00112233445566778899aabbccddeeff, `out_valid` 10 cycles after accept, `key_idx` sequence 10..0.
- Back-pressure: hold `out_ready=0` for 5 cycles after `out_valid` → output stable. `in_ready=0` throughout. Return to IDLE one edge after `out_ready=1`.
- Busy ignore: pulse `in_valid` with a different block at cycle T+4 → ignored. The first block's result is unchanged.
- Reset mid-operation: `rst_n=0` at round 5 → immediately `out_valid=0`, `in_ready=1`, `key_idx=10`. A subsequent FIPS vector decrypts correctly.
- Back-to-back: three blocks, with `in_valid` held and `out_ready=1` → accepts spaced exactly 12 cycles apart, all plaintexts correct.
- Round trip: 100 random key/plaintext pairs encrypted by the existing encryptor → decrypted output equals the original plaintext.
